// File: rtl/pwm_timebase.sv
// pwm_timebase: period/on-time counters, start sequencer and comparator synchroniser for the peak-current PWM FSM
// Build option PWM_TB_LEB_EN: leading-edge blanking of the comparator for the first BLANK on-time clocks
module pwm_timebase #(
`ifdef PWM_TB_LEB_EN
  parameter int BLANK = 8,
`endif
  parameter int WIDTH = 16,
  parameter int IDLE_MIN = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             reset_contador,
  input  logic             pwm,
  input  logic             cmp_raw,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] max_on,
  output logic             comp_frecuencia,
  output logic             comp_corriente,
  output logic             reset_contador_in,
  output logic [WIDTH-1:0] count
);
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] IDLE_LAST = WIDTH'(IDLE_MIN - 1);
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN} state_t;
  state_t state_q;
  logic [WIDTH-1:0] count_q, count_d, on_cnt_q, on_cnt_d, idle_cnt_q;
  logic comp_f_q, comp_f_d, comp_c_q, comp_c_d, rc_in_q, sync1_q, cmp_s_q, cmp_term;
  always_comb begin
    count_d = reset_contador ? '0 : (count_q == ONES ? count_q : count_q + 1'b1);
    on_cnt_d = !pwm ? '0 : (on_cnt_q == ONES ? on_cnt_q : on_cnt_q + 1'b1);
    // compares are done one bit wider so count+1 cannot wrap at all-ones
    comp_f_d = !reset_contador && (({1'b0, count_q} + 1'b1) >= {1'b0, period});
`ifdef PWM_TB_LEB_EN
    cmp_term = cmp_s_q && (on_cnt_q >= WIDTH'(BLANK));
`else
    cmp_term = cmp_s_q;
`endif
    comp_c_d = pwm && (cmp_term || (({1'b0, on_cnt_q} + 1'b1) >= {1'b0, max_on}));
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= '0;
      on_cnt_q <= '0;
      comp_f_q <= 1'b0;
      comp_c_q <= 1'b0;
      sync1_q  <= 1'b0;
      cmp_s_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      on_cnt_q <= on_cnt_d;
      comp_f_q <= comp_f_d;
      comp_c_q <= comp_c_d;
      sync1_q  <= cmp_raw;
      cmp_s_q  <= sync1_q;
    end
  end
  // idle_cnt restarts whenever the sequencer leaves the armed/run states so re-arming always waits IDLE_MIN clocks
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idle_cnt_q <= '0;
      rc_in_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!reset_contador) begin
            state_q    <= S_RUN;
            idle_cnt_q <= '0;
          end else begin
            if (idle_cnt_q != ONES) idle_cnt_q <= idle_cnt_q + 1'b1;
            if (enable && idle_cnt_q >= IDLE_LAST) begin
              state_q <= S_ARMED;
              rc_in_q <= 1'b1;
            end
          end
        end
        S_ARMED: begin
          if (!reset_contador) begin
            state_q    <= S_RUN;
            rc_in_q    <= 1'b0;
            idle_cnt_q <= '0;
          end else if (!enable) begin
            state_q    <= S_IDLE;
            rc_in_q    <= 1'b0;
            idle_cnt_q <= '0;
          end
        end
        S_RUN: begin
          rc_in_q    <= 1'b0;
          idle_cnt_q <= '0;
          if (reset_contador) state_q <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          rc_in_q    <= 1'b0;
          idle_cnt_q <= '0;
        end
      endcase
    end
  end
  assign comp_frecuencia   = comp_f_q;
  assign comp_corriente    = comp_c_q;
  assign reset_contador_in = rc_in_q;
  assign count             = count_q;
endmodule

// File: tb/tb_pwm_timebase.sv
// tb_pwm_timebase: scoreboard bench for pwm_timebase; expectations are queued per cycle, a negedge monitor checks them
module tb_pwm_timebase;
  localparam int W = 16;
  localparam int CF = 0, CC = 1, RC = 2, CNT = 3;
  logic clock = 1'b0;
  logic reset, enable, reset_contador, pwm, cmp_raw;
  logic [W-1:0] period, max_on, count;
  logic comp_frecuencia, comp_corriente, reset_contador_in;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  typedef struct {
    int    c;
    int    s;
    int    v;
    string nm;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  pwm_timebase dut (
    .clock(clock), .reset(reset), .enable(enable), .reset_contador(reset_contador),
    .pwm(pwm), .cmp_raw(cmp_raw), .period(period), .max_on(max_on),
    .comp_frecuencia(comp_frecuencia), .comp_corriente(comp_corriente),
    .reset_contador_in(reset_contador_in), .count(count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] obs(int s);
    return s == CF ? 32'(comp_frecuencia) : s == CC ? 32'(comp_corriente) :
           s == RC ? 32'(reset_contador_in) : 32'(count);
  endfunction

  task automatic push_exp(int d, int s, int v, string nm);
    exp_t e;
    int i;
    e = '{cyc + d, s, v, nm};
    i = 0;
    while (i < sb.size() && sb[i].c <= e.c) i++;
    sb.insert(i, e);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.c != cyc || obs(mon_e.s) !== 32'(mon_e.v)) begin
        failures++;
        $display("FAIL %s cyc=%0d (due %0d) got=%0d want=%0d", mon_e.nm, cyc, mon_e.c, obs(mon_e.s), mon_e.v);
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; reset_contador = 1'b0; pwm = 1'b0; cmp_raw = 1'b0;
    period = '0; max_on = '0;
    for (int i = 0; i < 3; i++) begin
      enable = 1'($urandom); reset_contador = 1'($urandom); pwm = 1'($urandom);
      cmp_raw = 1'($urandom); period = W'($urandom); max_on = W'($urandom);
      step(1);
      checks++;
      if (comp_frecuencia !== 1'b0 || comp_corriente !== 1'b0 || reset_contador_in !== 1'b0 || count !== '0) begin
        failures++;
        $display("FAIL reset_state cyc=%0d cf=%0b cc=%0b rc=%0b count=%0d", cyc, comp_frecuencia, comp_corriente, reset_contador_in, count);
      end
      push_exp(0, CF, 0, "rst_cf");
      push_exp(0, CC, 0, "rst_cc");
      push_exp(0, RC, 0, "rst_rc");
      push_exp(0, CNT, 0, "rst_count");
    end
    reset = 1'b0; enable = 1'b1; reset_contador = 1'b1; pwm = 1'b0; cmp_raw = 1'b0;
    period = 16'd10; max_on = 16'd20;
    push_exp(1, RC, 0, "arm_wait");
    push_exp(1, CNT, 0, "count_held");
    push_exp(2, RC, 1, "arm_rise");
    push_exp(5, RC, 1, "arm_hold");
    step(5);
    reset_contador = 1'b0;
    push_exp(1, RC, 0, "start_clear");
    for (int k = 1; k <= 10; k++) push_exp(k, CNT, k, "count_ramp");
    push_exp(9, CF, 0, "period_early");
    push_exp(10, CF, 1, "period_hit");
    step(10);
    push_exp(65530, CNT, 65535, "count_sat");
    push_exp(65530, CF, 1, "period_hold");
    step(65530);
    reset_contador = 1'b1;
    push_exp(1, CNT, 0, "count_clear");
    push_exp(1, CF, 0, "period_clear");
    push_exp(2, RC, 0, "rearm_wait");
    push_exp(3, RC, 1, "rearm");
    step(3);
    enable = 1'b0;
    push_exp(1, RC, 0, "disarm");
    step(1);
    enable = 1'b1;
    push_exp(1, RC, 0, "rearm_wait2");
    push_exp(2, RC, 1, "rearm2");
    step(2);
    pwm = 1'b1; max_on = 16'd20;
    push_exp(19, CC, 0, "maxon_early");
    push_exp(20, CC, 1, "maxon_hit");
    step(20);
    pwm = 1'b0;
    push_exp(1, CC, 0, "pwm_off");
    step(1);
    pwm = 1'b1;
    push_exp(19, CC, 0, "oncnt_cleared");
    push_exp(20, CC, 1, "maxon_hit2");
    step(20);
    pwm = 1'b0; max_on = 16'd0;
    step(1);
    pwm = 1'b1;
    push_exp(1, CC, 1, "maxon_zero");
    step(1);
    pwm = 1'b0;
    push_exp(1, CC, 0, "pwm_off2");
    step(2);
    max_on = 16'd1000; pwm = 1'b1;
    push_exp(4, CC, 0, "cmp_sync_lat");
`ifdef PWM_TB_LEB_EN
    push_exp(5, CC, 0, "leb_mask");
    push_exp(7, CC, 0, "leb_mask2");
`else
    push_exp(5, CC, 1, "cmp_early");
    push_exp(7, CC, 1, "cmp_early_hold");
    push_exp(8, CC, 0, "cmp_early_end");
`endif
    push_exp(14, CC, 0, "cmp_late_wait");
    push_exp(15, CC, 1, "cmp_late");
    step(2);
    cmp_raw = 1'b1;
    step(3);
    cmp_raw = 1'b0;
    step(7);
    cmp_raw = 1'b1;
    step(4);
    pwm = 1'b0; cmp_raw = 1'b0;
    step(2);
    period = 16'd0; reset_contador = 1'b0;
    push_exp(1, CF, 1, "period_zero");
    push_exp(1, RC, 0, "start_clear2");
    step(1);
    reset_contador = 1'b1;
    push_exp(1, CF, 0, "period_zero_clear");
    step(3);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL expired_wait %0d expectations never checked", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
